mem_misalign_ctrl: RTL and testbench

- Memory-stage access controller between the EX/MEM segment register and the data-memory port of the write-back segment register (which holds the synchronous-read data BRAM).
- Aligned and in-word byte/halfword accesses pass through in one access.
- Accesses that cross a word boundary are split into two aligned BRAM accesses, with a one-cycle pipeline stall.
- Load bytes are assembled and sign/zero extended.

---
 rtl/mem_misalign_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_misalign_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_misalign_ctrl.sv
// Memory-stage access controller. Splits word-crossing accesses into two aligned BRAM accesses and assembles/extends load data.
// Optional: define MEM_MISALIGN_TRAP_EN to trap word-crossing requests instead of splitting them.
module mem_misalign_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             req_load_i,
  input  logic             req_store_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic [31:0]      mem_a_o,
  output logic [31:0]      mem_wd_o,
  output logic [3:0]       mem_we_o,
  input  logic [31:0]      mem_rd_i,
  output logic             stall_o,
  output logic [31:0]      load_data_o,
  output logic             load_valid_o,
  output logic [CNT_W-1:0] split_cnt_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap_o
`endif
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t           state_q, state_d;
  logic [31:0]      low_q;
  logic             pend_load_q, pend_merge_q;
  logic [1:0]       pend_off_q;
  logic [2:0]       pend_f3_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0] off;
  logic [2:0] size;
  logic [3:0] mask;
  logic [2:0] hi_sh;
  logic       split, is_store, is_load, req_any;
  logic       issue_load, issue_merge, cnt_inc;
`ifdef MEM_MISALIGN_TRAP_EN
  logic       trap_d, trap_q;
`endif

  assign off      = req_addr_i[1:0];
  assign hi_sh    = 3'd4 - {1'b0, off};
  assign split    = ({1'b0, off} + size) > 3'd4;
  assign is_store = req_store_i;
  assign is_load  = req_load_i & ~req_store_i;
  // Reset is folded in so the combinational outputs read idle while reset is held.
  assign req_any  = (req_load_i | req_store_i) & en_i & ~clear_i & ~rst;

  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   begin size = 3'd1; mask = 4'h1; end
      2'b01:   begin size = 3'd2; mask = 4'h3; end
      default: begin size = 3'd4; mask = 4'hF; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_a_o     = req_addr_i;
    mem_wd_o    = req_wdata_i;
    mem_we_o    = '0;
    stall_o     = 1'b0;
    issue_load  = 1'b0;
    issue_merge = 1'b0;
    cnt_inc     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (split) begin
`ifdef MEM_MISALIGN_TRAP_EN
          trap_d  = req_any;
          cnt_inc = req_any;
`else
          mem_a_o  = {req_addr_i[31:2], 2'b00};
          mem_wd_o = req_wdata_i << {off, 3'b000};
          mem_we_o = (req_any && is_store) ? (mask << off) : '0;
          stall_o  = req_any;
          if (req_any) state_d = SECOND;
`endif
        end else begin
          mem_we_o   = (req_any && is_store) ? mask : '0;
          issue_load = req_any & is_load;
        end
      end
      SECOND: begin
        mem_a_o  = {req_addr_i[31:2] + 30'd1, 2'b00};
        mem_wd_o = req_wdata_i >> {hi_sh, 3'b000};
        state_d  = IDLE;
        if (en_i && !clear_i) begin
          mem_we_o    = is_store ? (mask >> hi_sh) : '0;
          issue_merge = is_load;
          cnt_inc     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      low_q        <= '0;
      pend_load_q  <= 1'b0;
      pend_merge_q <= 1'b0;
      pend_off_q   <= '0;
      pend_f3_q    <= '0;
      cnt_q        <= '0;
    end else if (en_i) begin
      state_q      <= state_d;
      if (state_q == SECOND) low_q <= mem_rd_i;
      pend_load_q  <= issue_load | issue_merge;
      pend_merge_q <= issue_merge;
      pend_off_q   <= off;
      pend_f3_q    <= req_funct3_i;
      if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
  assign misalign_trap_o = trap_q;
`endif

  logic [63:0] win;
  logic [31:0] sh32;

  // The merge window puts the high word above the captured low word, so one shift covers both cases.
  always_comb begin
    win  = pend_merge_q ? {mem_rd_i, low_q} : {32'h0, mem_rd_i};
    sh32 = 32'(win >> {pend_off_q, 3'b000});
    case (pend_f3_q[1:0])
      2'b00:   load_data_o = {{24{~pend_f3_q[2] & sh32[7]}}, sh32[7:0]};
      2'b01:   load_data_o = {{16{~pend_f3_q[2] & sh32[15]}}, sh32[15:0]};
      default: load_data_o = sh32;
    endcase
  end

  assign load_valid_o = pend_load_q & en_i;
  assign split_cnt_o  = cnt_q;

endmodule

// File: tb/tb_mem_misalign_ctrl.sv
// Directed testbench for mem_misalign_ctrl with a byte-enabled synchronous-read BRAM model.
module tb_mem_misalign_ctrl;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, en, clr, ld, st;
  logic [2:0]       f3;
  logic [31:0]      addr, wdata;
  logic [31:0]      mem_a, mem_wd, mem_rd, load_data;
  logic [3:0]       mem_we;
  logic             stall, load_valid;
  logic [CNT_W-1:0] split_cnt;
`ifdef MEM_MISALIGN_TRAP_EN
  logic             trap;
`endif

  mem_misalign_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en_i(en), .clear_i(clr),
    .req_load_i(ld), .req_store_i(st), .req_funct3_i(f3),
    .req_addr_i(addr), .req_wdata_i(wdata),
    .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_rd_i(mem_rd),
    .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid),
    .split_cnt_o(split_cnt)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap_o(trap)
`endif
  );

  always #5 clk = ~clk;

  // BRAM behind the WB segment register: it shifts data and enables by the low address bits.
  logic [31:0] mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  logic [3:0]  we_eff;
  logic [31:0] wd_eff;
  assign we_eff = mem_we << mem_a[1:0];
  assign wd_eff = mem_wd << {mem_a[1:0], 3'b000};

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else
      for (int b = 0; b < 4; b++)
        if (we_eff[b]) mem[mem_a[9:2]][8*b +: 8] <= wd_eff[8*b +: 8];
    mem_rd <= mem[mem_a[9:2]];
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic l, input logic s, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d);
    ld = l; st = s; f3 = fn; addr = a; wdata = d;
    #1;
  endtask

  task automatic clr_req();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    bd_idx = idx; bd_data = d; bd_we = 1'b1;
    step();
    bd_we = 1'b0;
  endtask

  task automatic load_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                         input logic is_split, input logic [31:0] exp);
    set_req(1'b1, 1'b0, fn, a, 32'h0);
    check_eq({tag, "_stall"}, {31'h0, stall}, {31'h0, is_split});
    if (is_split) begin
      check_eq({tag, "_a_lo"}, mem_a, {a[31:2], 2'b00});
      step();
      check_eq({tag, "_a_hi"}, mem_a, {a[31:2] + 30'd1, 2'b00});
      check_eq({tag, "_stall2"}, {31'h0, stall}, 32'h0);
      check_eq({tag, "_valid_early"}, {31'h0, load_valid}, 32'h0);
    end else begin
      check_eq({tag, "_a"}, mem_a, a);
    end
    step();
    clr_req();
    check_eq({tag, "_valid"}, {31'h0, load_valid}, 32'h1);
    check_eq({tag, "_data"}, load_data, exp);
    step();
    check_eq({tag, "_valid_off"}, {31'h0, load_valid}, 32'h0);
  endtask

  initial begin
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    rst = 1'b1; en = 1'b1; clr = 1'b0; ld = 1'b0; st = 1'b0; f3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bd_we = 1'b0; bd_idx = 8'h0; bd_data = 32'h0;
    #2;
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    check_eq("rst_we", {28'h0, mem_we}, 32'h0);
    check_eq("rst_valid", {31'h0, load_valid}, 32'h0);
    check_eq("rst_cnt", {30'h0, split_cnt}, 32'h0);

    preload(8'h40, 32'h44332211);
    preload(8'h41, 32'h88776655);
    preload(8'h42, 32'hCAFEF00D);
    preload(8'hFF, 32'hDDCCBBAA);
    preload(8'h00, 32'h12345678);
    rst = 1'b0;
    #1;

`ifdef MEM_MISALIGN_TRAP_EN
    set_req(1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'hAABBCCDD);
    check_eq("trap_stall", {31'h0, stall}, 32'h0);
    check_eq("trap_we", {28'h0, mem_we}, 32'h0);
    check_eq("trap_pre", {31'h0, trap}, 32'h0);
    step();
    clr_req();
    check_eq("trap_pulse", {31'h0, trap}, 32'h1);
    check_eq("trap_cnt", {30'h0, split_cnt}, 32'h1);
    check_eq("trap_mem", mem[8'h40], 32'h44332211);
    step();
    check_eq("trap_clear", {31'h0, trap}, 32'h0);
    set_req(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
    check_eq("trap_lw_stall", {31'h0, stall}, 32'h0);
    step();
    clr_req();
    check_eq("trap_lw_pulse", {31'h0, trap}, 32'h1);
    check_eq("trap_lw_valid", {31'h0, load_valid}, 32'h0);
    check_eq("trap_lw_cnt", {30'h0, split_cnt}, 32'h2);
`else
    load_op("lw_split", 3'b010, 32'h0000_0102, 1'b1, 32'h66554433);
    check_eq("cnt1", {30'h0, split_cnt}, 32'h1);
    load_op("lh_split", 3'b001, 32'h0000_0103, 1'b1, 32'h00005544);
    check_eq("cnt2", {30'h0, split_cnt}, 32'h2);
    load_op("lb", 3'b000, 32'h0000_0107, 1'b0, 32'hFFFFFF88);
    load_op("lbu", 3'b100, 32'h0000_0107, 1'b0, 32'h00000088);
    load_op("lw", 3'b010, 32'h0000_0104, 1'b0, 32'h88776655);

    set_req(1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'hAABBCCDD);
    check_eq("sw_a_lo", mem_a, 32'h0000_0100);
    check_eq("sw_we_lo", {28'h0, mem_we}, 32'hE);
    check_eq("sw_wd_lo", mem_wd, 32'hBBCCDD00);
    check_eq("sw_stall", {31'h0, stall}, 32'h1);
    step();
    check_eq("sw_a_hi", mem_a, 32'h0000_0104);
    check_eq("sw_we_hi", {28'h0, mem_we}, 32'h1);
    check_eq("sw_wd_hi", mem_wd, 32'h000000AA);
    check_eq("sw_stall2", {31'h0, stall}, 32'h0);
    step();
    clr_req();
    check_eq("sw_no_valid", {31'h0, load_valid}, 32'h0);
    check_eq("sw_mem_lo", mem[8'h40], 32'hBBCCDD11);
    check_eq("sw_mem_hi", mem[8'h41], 32'h887766AA);
    check_eq("cnt3", {30'h0, split_cnt}, 32'h3);

    load_op("lw_wrap", 3'b010, 32'hFFFF_FFFE, 1'b1, 32'h5678DDCC);
    check_eq("cnt_sat", {30'h0, split_cnt}, 32'h3);

    set_req(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h01020304);
    check_eq("ldst_we", {28'h0, mem_we}, 32'hF);
    step();
    clr_req();
    check_eq("ldst_no_valid", {31'h0, load_valid}, 32'h0);
    check_eq("ldst_mem", mem[8'h40], 32'h01020304);

    en = 1'b0;
    set_req(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'hFFFFFFFF);
    check_eq("en0_stall", {31'h0, stall}, 32'h0);
    check_eq("en0_we", {28'h0, mem_we}, 32'h0);
    step();
    en = 1'b1;
    clr_req();
    check_eq("en0_hold_idle", {31'h0, stall}, 32'h0);
    check_eq("en0_mem", mem[8'h40], 32'h01020304);

    clr = 1'b1;
    set_req(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
    check_eq("clr_idle_stall", {31'h0, stall}, 32'h0);
    step();
    clr = 1'b0;
    clr_req();
    check_eq("clr_idle_valid", {31'h0, load_valid}, 32'h0);

    set_req(1'b0, 1'b1, 3'b010, 32'h0000_0106, 32'h11223344);
    check_eq("rstmid_stall", {31'h0, stall}, 32'h1);
    check_eq("rstmid_we_lo", {28'h0, mem_we}, 32'hC);
    check_eq("rstmid_wd_lo", mem_wd, 32'h33440000);
    step();
    rst = 1'b1;
    #1;
    check_eq("rstmid_stall2", {31'h0, stall}, 32'h0);
    check_eq("rstmid_we_hi", {28'h0, mem_we}, 32'h0);
    step();
    clr_req();
    rst = 1'b0;
    #1;
    check_eq("rstmid_idle", {31'h0, stall}, 32'h0);
    check_eq("rstmid_mem_lo", mem[8'h41], 32'h334466AA);
    check_eq("rstmid_mem_hi", mem[8'h42], 32'hCAFEF00D);
    check_eq("rstmid_cnt", {30'h0, split_cnt}, 32'h0);

    set_req(1'b0, 1'b1, 3'b010, 32'h0000_0106, 32'h55667788);
    check_eq("clrsec_stall", {31'h0, stall}, 32'h1);
    step();
    clr = 1'b1;
    #1;
    check_eq("clrsec_we", {28'h0, mem_we}, 32'h0);
    step();
    clr = 1'b0;
    clr_req();
    check_eq("clrsec_mem_lo", mem[8'h41], 32'h778866AA);
    check_eq("clrsec_mem_hi", mem[8'h42], 32'hCAFEF00D);
    check_eq("clrsec_cnt", {30'h0, split_cnt}, 32'h0);

    set_req(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0);
    step();
    clr = 1'b1;
    #1;
    step();
    clr = 1'b0;
    clr_req();
    check_eq("clrsec_ld_valid", {31'h0, load_valid}, 32'h0);
    check_eq("clrsec_ld_cnt", {30'h0, split_cnt}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      load_op("sat_lw", 3'b010, 32'h0000_0102, 1'b1, 32'h66AA0102);
      check_eq("sat_cnt", {30'h0, split_cnt}, exp_cnt[i]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
